axi_lite_master: RTL and testbench

//  Command-driven AXI-Lite master that issues single read/write transactions to the 16x8 register

---
 rtl/axi_lite_master_if.sv | 46 ++++
 rtl/axi_lite_master.sv | 210 +++++++++++++++++++++
 tb/tb_axi_lite_master.sv | 474 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_master_if.sv
// Bundles the command/response port and the AXI-Lite AR/R/AW/W/B channels of axi_lite_master.
interface axi_lite_master_if #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8
);
  // Local requester side
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  // AXI-Lite read channels
  logic [ADDR_W-1:0] read_address;
  logic              AR_VALID;
  logic              AR_READY;
  logic [DATA_W-1:0] data_read;
  logic              R_VALID;
  logic              R_READY;
  // AXI-Lite write channels
  logic [ADDR_W-1:0] write_address;
  logic              AW_VALID;
  logic              AW_READY;
  logic [DATA_W-1:0] write_data;
  logic              W_VALID;
  logic              W_READY;
  logic              B_VALID;
  logic              B_READY;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    input  AR_READY, data_read, R_VALID, AW_READY, W_READY, B_VALID,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    output read_address, AR_VALID, R_READY, write_address, AW_VALID, write_data, W_VALID, B_READY
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    output AR_READY, data_read, R_VALID, AW_READY, W_READY, B_VALID,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    input  read_address, AR_VALID, R_READY, write_address, AW_VALID, write_data, W_VALID, B_READY
  );
endinterface

// File: rtl/axi_lite_master.sv
// Command-driven AXI-Lite master: one read or write in flight, per-channel handshake timeout,
// fully registered outputs.
module axi_lite_master #(
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned TIMEOUT = 255
) (
  input logic               s_clk,
  input logic               rst,
  axi_lite_master_if.master bus
);

  // Counter only has to reach TIMEOUT-1
  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {StIdle, StAr, StR, StAw, StW, StB, StRsp} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic [ADDR_W-1:0] read_address_q, read_address_d;
  logic              ar_valid_q, ar_valid_d;
  logic              r_ready_q, r_ready_d;
  logic [ADDR_W-1:0] write_address_q, write_address_d;
  logic              aw_valid_q, aw_valid_d;
  logic [DATA_W-1:0] write_data_q, write_data_d;
  logic              w_valid_q, w_valid_d;
  logic              b_ready_q, b_ready_d;
  logic              timeout_hit;
  logic              abort;

  // TIMEOUT == 0 disables the guard entirely
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CntW'(TIMEOUT - 1));

  // Next-state and registered-output logic; abort collapses any channel wait into an error response
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    wdata_d         = wdata_q;
    cmd_ready_d     = cmd_ready_q;
    rsp_valid_d     = rsp_valid_q;
    rsp_rdata_d     = rsp_rdata_q;
    rsp_err_d       = rsp_err_q;
    read_address_d  = read_address_q;
    ar_valid_d      = ar_valid_q;
    r_ready_d       = r_ready_q;
    write_address_d = write_address_q;
    aw_valid_d      = aw_valid_q;
    write_data_d    = write_data_q;
    w_valid_d       = w_valid_q;
    b_ready_d       = b_ready_q;
    abort           = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          cnt_d       = '0;
          if (bus.cmd_write) begin
            write_address_d = bus.cmd_addr;
            wdata_d         = bus.cmd_wdata;
            aw_valid_d      = 1'b1;
            state_d         = StAw;
          end else begin
            read_address_d = bus.cmd_addr;
            ar_valid_d     = 1'b1;
            state_d        = StAr;
          end
        end
      end
      StAr: begin
        if (bus.AR_READY) begin
          ar_valid_d = 1'b0;
          r_ready_d  = 1'b1;
          cnt_d      = '0;
          state_d    = StR;
        end else if (timeout_hit) begin
          abort = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StR: begin
        if (bus.R_VALID) begin
          rsp_rdata_d = bus.data_read;
          r_ready_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = StRsp;
        end else if (timeout_hit) begin
          abort = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StAw: begin
        if (bus.AW_READY) begin
          aw_valid_d   = 1'b0;
          w_valid_d    = 1'b1;
          write_data_d = wdata_q;
          cnt_d        = '0;
          state_d      = StW;
        end else if (timeout_hit) begin
          abort = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StW: begin
        if (bus.W_READY) begin
          w_valid_d = 1'b0;
          b_ready_d = 1'b1;
          cnt_d     = '0;
          state_d   = StB;
        end else if (timeout_hit) begin
          abort = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StB: begin
        if (bus.B_VALID) begin
          b_ready_d   = 1'b0;
          rsp_rdata_d = '0;
          rsp_valid_d = 1'b1;
          state_d     = StRsp;
        end else if (timeout_hit) begin
          abort = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StRsp: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (abort) begin
      ar_valid_d  = 1'b0;
      r_ready_d   = 1'b0;
      aw_valid_d  = 1'b0;
      w_valid_d   = 1'b0;
      b_ready_d   = 1'b0;
      rsp_rdata_d = '0;
      rsp_err_d   = 1'b1;
      rsp_valid_d = 1'b1;
      state_d     = StRsp;
    end
  end

  // State and output registers with synchronous active-high reset
  always_ff @(posedge s_clk) begin
    if (rst) begin
      state_q         <= StIdle;
      cnt_q           <= '0;
      wdata_q         <= '0;
      cmd_ready_q     <= 1'b1;
      rsp_valid_q     <= 1'b0;
      rsp_rdata_q     <= '0;
      rsp_err_q       <= 1'b0;
      read_address_q  <= '0;
      ar_valid_q      <= 1'b0;
      r_ready_q       <= 1'b0;
      write_address_q <= '0;
      aw_valid_q      <= 1'b0;
      write_data_q    <= '0;
      w_valid_q       <= 1'b0;
      b_ready_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      wdata_q         <= wdata_d;
      cmd_ready_q     <= cmd_ready_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_rdata_q     <= rsp_rdata_d;
      rsp_err_q       <= rsp_err_d;
      read_address_q  <= read_address_d;
      ar_valid_q      <= ar_valid_d;
      r_ready_q       <= r_ready_d;
      write_address_q <= write_address_d;
      aw_valid_q      <= aw_valid_d;
      write_data_q    <= write_data_d;
      w_valid_q       <= w_valid_d;
      b_ready_q       <= b_ready_d;
    end
  end

  assign bus.cmd_ready     = cmd_ready_q;
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_rdata     = rsp_rdata_q;
  assign bus.rsp_err       = rsp_err_q;
  assign bus.read_address  = read_address_q;
  assign bus.AR_VALID      = ar_valid_q;
  assign bus.R_READY       = r_ready_q;
  assign bus.write_address = write_address_q;
  assign bus.AW_VALID      = aw_valid_q;
  assign bus.write_data    = write_data_q;
  assign bus.W_VALID       = w_valid_q;
  assign bus.B_READY       = b_ready_q;

endmodule

// File: tb/tb_axi_lite_master.sv
// Bench for axi_lite_master: behavioural 16x8 slave with stall knobs, reference memory model,
// scenario tasks sampling at the falling edge.
module tb_axi_lite_master;
  localparam int unsigned AW = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned TO = 8;

  logic s_clk = 1'b0;
  logic rst;
  always #5 s_clk = ~s_clk;

  axi_lite_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  axi_lite_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .s_clk (s_clk),
    .rst   (rst),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Slave knobs
  logic        ar_en, w_en, stale;
  int unsigned max_stall;

  // Behavioural slave; mem preset on reset to mem[i] = {i, i}
  logic [7:0]  mem [16];
  logic [3:0]  waddr;
  logic        rpend, bpend;
  int unsigned dly;

  always @(posedge s_clk) begin
    if (rst) begin
      bus.AR_READY  <= 1'b0;
      bus.R_VALID   <= 1'b0;
      bus.AW_READY  <= 1'b0;
      bus.W_READY   <= 1'b0;
      bus.B_VALID   <= 1'b0;
      bus.data_read <= '0;
      rpend         <= 1'b0;
      bpend         <= 1'b0;
      dly           <= 0;
      waddr         <= '0;
      for (int i = 0; i < 16; i++) mem[i] <= {i[3:0], i[3:0]};
    end else begin
      if (dly != 0) dly <= dly - 1;
      if (bus.AR_VALID && bus.AR_READY) begin
        bus.AR_READY  <= 1'b0;
        bus.data_read <= mem[bus.read_address];
        rpend         <= 1'b1;
      end else if (bus.AR_VALID && ar_en && dly == 0) begin
        bus.AR_READY <= 1'b1;
        dly          <= $urandom_range(max_stall, 0);
      end
      if (bus.R_VALID && bus.R_READY) begin
        bus.R_VALID <= stale;
        rpend       <= 1'b0;
      end else if (rpend && bus.R_READY && dly == 0) begin
        bus.R_VALID <= 1'b1;
        dly         <= $urandom_range(max_stall, 0);
      end
      if (bus.AW_VALID && bus.AW_READY) begin
        bus.AW_READY <= 1'b0;
        waddr        <= bus.write_address;
      end else if (bus.AW_VALID && dly == 0) begin
        bus.AW_READY <= 1'b1;
        dly          <= $urandom_range(max_stall, 0);
      end
      if (bus.W_VALID && bus.W_READY) begin
        bus.W_READY <= 1'b0;
        mem[waddr]  <= bus.write_data;
        bpend       <= 1'b1;
      end else if (bus.W_VALID && w_en && dly == 0) begin
        bus.W_READY <= 1'b1;
        dly         <= $urandom_range(max_stall, 0);
      end
      if (bus.B_VALID && bus.B_READY) begin
        bus.B_VALID <= 1'b0;
        bpend       <= 1'b0;
      end else if (bpend && bus.B_READY && dly == 0) begin
        bus.B_VALID <= 1'b1;
        dly         <= $urandom_range(max_stall, 0);
      end
    end
  end

  // Response handshake counter
  int rsp_cnt = 0;
  always @(posedge s_clk) begin
    if (bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) rsp_cnt <= rsp_cnt + 1;
  end

  // Protocol monitor: no VALID drop before handshake (unless error response), W only after AW
  logic p_arv, p_arr, p_awv, p_awr, p_wv, p_wr, aw_seen, rst_seen;
  int   viol = 0;
  always @(posedge s_clk) begin
    rst_seen <= rst;
    if (rst || (bus.cmd_valid && bus.cmd_ready)) aw_seen <= 1'b0;
    else if (bus.AW_VALID && bus.AW_READY) aw_seen <= 1'b1;
  end
  always @(negedge s_clk) begin
    p_arv <= bus.AR_VALID;
    p_arr <= bus.AR_READY;
    p_awv <= bus.AW_VALID;
    p_awr <= bus.AW_READY;
    p_wv  <= bus.W_VALID;
    p_wr  <= bus.W_READY;
    if (rst_seen === 1'b0) begin
      if (p_arv && !p_arr && !bus.AR_VALID && !bus.rsp_err) viol <= viol + 1;
      if (p_awv && !p_awr && !bus.AW_VALID && !bus.rsp_err) viol <= viol + 1;
      if (p_wv && !p_wr && !bus.W_VALID && !bus.rsp_err) viol <= viol + 1;
      if (bus.W_VALID && !aw_seen) viol <= viol + 1;
    end
  end

  // Reference model: expected register contents
  logic [7:0] ref_mem [16];
  task automatic ref_init();
    for (int i = 0; i < 16; i++) ref_mem[i] = 8'(i * 17);
  endtask

  // Issue one command and consume its response after `hold` extra cycles.
  // lat counts the accept cycle as 1 and ends at the first cycle rsp_valid is seen.
  task automatic run_cmd(input logic wr, input logic [3:0] a, input logic [7:0] d,
                         input int hold, output logic [7:0] rdata, output logic err,
                         output int lat);
    int n;
    rdata = '0;
    err   = 1'b0;
    lat   = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    n = 0;
    while (bus.cmd_ready !== 1'b1 && n < 20) begin
      @(negedge s_clk);
      n++;
    end
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL cmd_accept: cmd_ready=%b required 1", bus.cmd_ready);
      bus.cmd_valid = 1'b0;
      return;
    end
    @(negedge s_clk);
    bus.cmd_valid = 1'b0;
    lat = 1;
    while (bus.rsp_valid !== 1'b1 && lat < 40) begin
      @(negedge s_clk);
      lat++;
    end
    checks++;
    if (bus.rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL rsp_wait: rsp_valid=%b required 1 within 40 cycles", bus.rsp_valid);
      return;
    end
    rdata = bus.rsp_rdata;
    err   = bus.rsp_err;
    repeat (hold) @(negedge s_clk);
    bus.rsp_ready = 1'b1;
    @(negedge s_clk);
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge s_clk);
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      errors++; $display("FAIL reset_cmd_ready: got %b required 1", bus.cmd_ready);
    end
    checks++;
    if ({bus.AR_VALID, bus.R_READY, bus.AW_VALID, bus.W_VALID, bus.B_READY, bus.rsp_valid,
         bus.rsp_err} !== 7'b0) begin
      errors++; $display("FAIL reset_flags: ar%b r%b aw%b w%b b%b rv%b re%b required all 0",
                         bus.AR_VALID, bus.R_READY, bus.AW_VALID, bus.W_VALID, bus.B_READY,
                         bus.rsp_valid, bus.rsp_err);
    end
    checks++;
    if ({bus.read_address, bus.write_address, bus.write_data, bus.rsp_rdata} !== 24'h0) begin
      errors++; $display("FAIL reset_data: ra=%h wa=%h wd=%h rd=%h required 0",
                         bus.read_address, bus.write_address, bus.write_data, bus.rsp_rdata);
    end
    rst = 1'b0;
    ref_init();
    repeat (2) @(negedge s_clk);
    checks++;
    if (bus.cmd_ready !== 1'b1 || bus.AR_VALID !== 1'b0 || bus.AW_VALID !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset: cmd_ready=%b ar=%b aw=%b required 1 0 0",
                         bus.cmd_ready, bus.AR_VALID, bus.AW_VALID);
    end
  endtask

  task automatic test_read_basic();
    logic [7:0] rd; logic er; int lat; int start;
    max_stall = 0;
    start = rsp_cnt;
    run_cmd(1'b0, 4'h5, 8'h00, 0, rd, er, lat);
    checks++;
    if (rd !== ref_mem[5] || er !== 1'b0) begin
      errors++; $display("FAIL read5: rdata=%h err=%b required %h 0", rd, er, ref_mem[5]);
    end
    checks++;
    if (lat !== 5) begin
      errors++; $display("FAIL read_latency: got %0d required 5", lat);
    end
    checks++;
    if (rsp_cnt - start !== 1) begin
      errors++; $display("FAIL read_one_rsp: got %0d responses required 1", rsp_cnt - start);
    end
  endtask

  task automatic test_write_read();
    logic [7:0] rd; logic er; int lat;
    max_stall = 0;
    run_cmd(1'b1, 4'hA, 8'h3C, 0, rd, er, lat);
    ref_mem[10] = 8'h3C;
    checks++;
    if (rd !== 8'h00 || er !== 1'b0) begin
      errors++; $display("FAIL write_rsp: rdata=%h err=%b required 00 0", rd, er);
    end
    checks++;
    if (lat !== 7) begin
      errors++; $display("FAIL write_latency: got %0d required 7", lat);
    end
    run_cmd(1'b0, 4'hA, 8'h00, 0, rd, er, lat);
    checks++;
    if (rd !== ref_mem[10] || er !== 1'b0) begin
      errors++; $display("FAIL readback_A: rdata=%h err=%b required %h 0", rd, er, ref_mem[10]);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] rd; logic er; int lat;
    logic       wrs [3];
    logic [3:0] adr [3];
    logic [7:0] dat [3];
    wrs[0] = 1'b1; adr[0] = 4'h1; dat[0] = 8'h5A;
    wrs[1] = 1'b0; adr[1] = 4'h1; dat[1] = 8'h00;
    wrs[2] = 1'b1; adr[2] = 4'h2; dat[2] = 8'hA5;
    max_stall = 0;
    for (int k = 0; k < 3; k++) begin
      run_cmd(wrs[k], adr[k], dat[k], 0, rd, er, lat);
      checks++;
      if (lat !== (wrs[k] ? 7 : 5)) begin
        errors++; $display("FAIL b2b_latency[%0d]: got %0d required %0d", k, lat,
                           wrs[k] ? 7 : 5);
      end
      checks++;
      if (rd !== (wrs[k] ? 8'h00 : ref_mem[adr[k]]) || er !== 1'b0) begin
        errors++; $display("FAIL b2b_data[%0d]: rdata=%h err=%b", k, rd, er);
      end
      if (wrs[k]) ref_mem[adr[k]] = dat[k];
      checks++;
      if (bus.cmd_ready !== 1'b1) begin
        errors++; $display("FAIL b2b_ready[%0d]: cmd_ready=%b required 1", k, bus.cmd_ready);
      end
    end
  endtask

  task automatic test_timeout();
    int t; logic early_drop;
    ar_en = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 4'h2;
    bus.cmd_wdata = 8'h00;
    @(negedge s_clk);
    bus.cmd_valid = 1'b0;
    checks++;
    if (bus.AR_VALID !== 1'b1) begin
      errors++; $display("FAIL to_ar_rise: AR_VALID=%b required 1", bus.AR_VALID);
    end
    t = 0;
    early_drop = 1'b0;
    while (bus.rsp_valid !== 1'b1 && t < 20) begin
      @(negedge s_clk);
      t++;
      if (bus.rsp_valid !== 1'b1 && bus.AR_VALID !== 1'b1) early_drop = 1'b1;
    end
    checks++;
    if (t !== TO) begin
      errors++; $display("FAIL to_cycles: got %0d required %0d", t, TO);
    end
    checks++;
    if (early_drop !== 1'b0) begin
      errors++; $display("FAIL to_ar_held: AR_VALID dropped before timeout");
    end
    checks++;
    if (bus.rsp_err !== 1'b1 || bus.rsp_rdata !== 8'h00 || bus.AR_VALID !== 1'b0 ||
        bus.R_READY !== 1'b0) begin
      errors++; $display("FAIL to_rsp: err=%b rdata=%h ar=%b r=%b required 1 00 0 0",
                         bus.rsp_err, bus.rsp_rdata, bus.AR_VALID, bus.R_READY);
    end
    bus.rsp_ready = 1'b1;
    @(negedge s_clk);
    bus.rsp_ready = 1'b0;
    ar_en = 1'b1;
    checks++;
    if (bus.cmd_ready !== 1'b1 || bus.rsp_err !== 1'b0) begin
      errors++; $display("FAIL to_recover: cmd_ready=%b err=%b required 1 0",
                         bus.cmd_ready, bus.rsp_err);
    end
  endtask

  task automatic test_stale_rvalid();
    logic [7:0] rd; logic er; int lat;
    max_stall = 0;
    stale = 1'b1;
    run_cmd(1'b0, 4'h5, 8'h00, 0, rd, er, lat);
    checks++;
    if (rd !== ref_mem[5]) begin
      errors++; $display("FAIL stale_first: rdata=%h required %h", rd, ref_mem[5]);
    end
    stale = 1'b0;
    repeat (2) @(negedge s_clk);
    run_cmd(1'b0, 4'h3, 8'h00, 0, rd, er, lat);
    checks++;
    if (rd !== ref_mem[3] || er !== 1'b0) begin
      errors++; $display("FAIL stale_second: rdata=%h err=%b required %h 0", rd, er, ref_mem[3]);
    end
  endtask

  task automatic test_rsp_hold();
    int n;
    max_stall = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 4'h7;
    @(negedge s_clk);
    bus.cmd_valid = 1'b0;
    n = 0;
    while (bus.rsp_valid !== 1'b1 && n < 40) begin
      @(negedge s_clk);
      n++;
    end
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== ref_mem[7]) begin
        errors++; $display("FAIL hold_rsp[%0d]: valid=%b rdata=%h required 1 %h", c,
                           bus.rsp_valid, bus.rsp_rdata, ref_mem[7]);
      end
      checks++;
      if (bus.cmd_ready !== 1'b0 || {bus.AR_VALID, bus.R_READY, bus.AW_VALID, bus.W_VALID,
                                     bus.B_READY} !== 5'b0) begin
        errors++; $display("FAIL hold_quiet[%0d]: cmd_ready=%b ar%b r%b aw%b w%b b%b required 0",
                           c, bus.cmd_ready, bus.AR_VALID, bus.R_READY, bus.AW_VALID,
                           bus.W_VALID, bus.B_READY);
      end
      @(negedge s_clk);
    end
    bus.rsp_ready = 1'b1;
    @(negedge s_clk);
    bus.rsp_ready = 1'b0;
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
      errors++; $display("FAIL hold_release: valid=%b cmd_ready=%b required 0 1",
                         bus.rsp_valid, bus.cmd_ready);
    end
  endtask

  task automatic test_reset_mid_w();
    logic [7:0] rd; logic er; int lat; int n; int start;
    max_stall = 0;
    w_en = 1'b0;
    start = rsp_cnt;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 4'h6;
    bus.cmd_wdata = 8'h99;
    @(negedge s_clk);
    bus.cmd_valid = 1'b0;
    n = 0;
    while (bus.W_VALID !== 1'b1 && n < 20) begin
      @(negedge s_clk);
      n++;
    end
    checks++;
    if (bus.W_VALID !== 1'b1) begin
      errors++; $display("FAIL midw_reach: W_VALID=%b required 1", bus.W_VALID);
    end
    rst = 1'b1;
    @(negedge s_clk);
    checks++;
    if (bus.W_VALID !== 1'b0 || bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
      errors++; $display("FAIL midw_reset: w=%b cmd_ready=%b rsp_valid=%b required 0 1 0",
                         bus.W_VALID, bus.cmd_ready, bus.rsp_valid);
    end
    rst = 1'b0;
    w_en = 1'b1;
    ref_init();
    repeat (3) @(negedge s_clk);
    checks++;
    if (rsp_cnt !== start || bus.rsp_valid !== 1'b0) begin
      errors++; $display("FAIL midw_no_rsp: responses=%0d rsp_valid=%b required 0 0",
                         rsp_cnt - start, bus.rsp_valid);
    end
    run_cmd(1'b1, 4'h6, 8'hC3, 0, rd, er, lat);
    ref_mem[6] = 8'hC3;
    checks++;
    if (er !== 1'b0 || rd !== 8'h00 || lat !== 7) begin
      errors++; $display("FAIL midw_new_write: err=%b rdata=%h lat=%0d required 0 00 7",
                         er, rd, lat);
    end
    run_cmd(1'b0, 4'h6, 8'h00, 0, rd, er, lat);
    checks++;
    if (rd !== ref_mem[6] || er !== 1'b0) begin
      errors++; $display("FAIL midw_readback: rdata=%h err=%b required %h 0", rd, er, ref_mem[6]);
    end
  endtask

  task automatic test_random();
    logic [7:0] rd, d, exp; logic er, wr; logic [3:0] a; int lat; int hold;
    max_stall = 3;
    for (int k = 0; k < 40; k++) begin
      wr   = 1'($urandom_range(1, 0));
      a    = 4'($urandom_range(15, 0));
      d    = 8'($urandom_range(255, 0));
      hold = $urandom_range(3, 0);
      exp  = wr ? 8'h00 : ref_mem[a];
      run_cmd(wr, a, d, hold, rd, er, lat);
      if (wr) ref_mem[a] = d;
      checks++;
      if (rd !== exp || er !== 1'b0) begin
        errors++; $display("FAIL random[%0d]: wr=%b addr=%h rdata=%h err=%b required %h 0",
                           k, wr, a, rd, er, exp);
      end
    end
    max_stall = 0;
  endtask

  task automatic test_protocol();
    checks++;
    if (viol !== 0) begin
      errors++; $display("FAIL protocol: %0d handshake violations required 0", viol);
    end
  endtask

  initial begin
    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b0;
    ar_en         = 1'b1;
    w_en          = 1'b1;
    stale         = 1'b0;
    max_stall     = 0;
    test_reset();
    test_read_basic();
    test_write_read();
    test_back_to_back();
    test_timeout();
    test_stale_rvalid();
    test_rsp_hold();
    test_reset_mid_w();
    test_random();
    test_protocol();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
